tx_gmii_frame_packer: RTL and testbench

- Downstream consumer of the 128-to-8 TX prefetch FIFO.
- Pulls a fixed-length payload one byte at a time from the FIFO's byte read port and wraps it as a GMII frame: 7-byte preamble, SFD, payload, then CRC-32 FCS.
- Enforces the inter-frame gap before the next frame, and drives the Ethernet PHY TX interface directly.

---
 rtl/tx_gmii_pkg.sv | 22 ++
 rtl/tx_gmii_frame_packer_crc32_d8.sv | 22 ++
 rtl/tx_gmii_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_tx_gmii_frame_packer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_gmii_pkg.sv
// Shared constants and state encoding for the GMII TX frame packer.
// Imported by the packer top and its CRC stepping sub-module.
package tx_gmii_pkg;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  localparam int unsigned PRE_LEN = 7;
  localparam int unsigned FCS_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } state_e;

endpackage

// File: rtl/tx_gmii_frame_packer_crc32_d8.sv
// Reflected CRC-32 advanced by one data byte, LSB first.
// Purely combinational.
module crc32_d8
  import tx_gmii_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_c[0] ^ i_data[i]) w_c = (w_c >> 1) ^ CRC_POLY;
      else                    w_c = w_c >> 1;
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/tx_gmii_frame_packer.sv
// Wraps fixed-length FIFO payloads as GMII frames:
// preamble, SFD, payload, FCS, then inter-frame gap.
module tx_gmii_frame_packer
  import tx_gmii_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned LEN_W       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       fifo_rd_en,
  input  logic       fifo_rd_vld,
  input  logic [7:0] fifo_rd_data,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [LEN_W-1:0] LAST_POS = LEN_W'(PAYLOAD_LEN - 1);
  localparam logic [7:0] LAST_PRE  = 8'(PRE_LEN - 1);
  localparam logic [7:0] LAST_FCS  = 8'(FCS_LEN - 1);
  localparam logic [7:0] DONE_SEQ  = 8'(FCS_LEN - 2);
  localparam logic [7:0] LAST_IFG  = 8'(IFG_CYCLES - 1);

  state_e           r_state, w_state_n;
  logic [LEN_W-1:0] r_pos, w_pos_n;
  logic [7:0]       r_seq, w_seq_n;
  logic [31:0]      r_crc, w_crc_in, w_crc_nx, w_inv;
  logic             r_urun_seen, w_urun_seen_n;
  logic             w_slot;
  logic [7:0]       w_pay, w_fcs_b, w_txd_n;
  logic             w_en_n, w_er_n, w_busy_n;
  logic             w_done_n, w_urun_n;

  // State tracks the byte on the wire; the pop runs one
  // cycle ahead so the byte lands in its own slot.
  assign w_slot = (r_state == ST_SFD) ||
                  (r_state == ST_PAYLOAD && r_pos != LAST_POS);
  assign fifo_rd_en = w_slot && fifo_rd_vld;
  assign w_pay = fifo_rd_vld ? fifo_rd_data : 8'h00;
  assign w_crc_in = (r_state == ST_SFD) ? CRC_INIT : r_crc;
  assign w_inv = ~r_crc;
  assign w_fcs_b = 8'(w_inv >> {r_seq[1:0] + 2'd1, 3'b000});

  crc32_d8 u_crc (
    .i_crc  (w_crc_in),
    .i_data (w_pay),
    .o_crc  (w_crc_nx)
  );

  always_comb begin
    w_state_n     = r_state;
    w_pos_n       = r_pos;
    w_seq_n       = r_seq;
    w_urun_seen_n = r_urun_seen;
    w_en_n        = 1'b0;
    w_er_n        = 1'b0;
    w_txd_n       = 8'h00;
    w_busy_n      = 1'b1;
    w_done_n      = 1'b0;
    w_urun_n      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy_n = 1'b0;
        if (start) begin
          w_state_n     = ST_PRE;
          w_seq_n       = '0;
          w_urun_seen_n = 1'b0;
          w_en_n        = 1'b1;
          w_txd_n       = PRE_BYTE;
          w_busy_n      = 1'b1;
        end
      end
      ST_PRE: begin
        w_en_n = 1'b1;
        if (r_seq == LAST_PRE) begin
          w_state_n = ST_SFD;
          w_txd_n   = SFD_BYTE;
        end else begin
          w_seq_n = r_seq + 8'd1;
          w_txd_n = PRE_BYTE;
        end
      end
      ST_SFD, ST_PAYLOAD: begin
        w_en_n = 1'b1;
        if (w_slot) begin
          w_txd_n = w_pay;
          if (!fifo_rd_vld) begin
            w_urun_seen_n = 1'b1;
            w_urun_n      = !r_urun_seen;
          end
          if (r_state == ST_SFD) begin
            w_state_n = ST_PAYLOAD;
            w_pos_n   = '0;
          end else begin
            w_pos_n = r_pos + 1'b1;
          end
        end else begin
          w_state_n = ST_FCS;
          w_seq_n   = '0;
          w_txd_n   = w_inv[7:0];
        end
        w_er_n = w_urun_seen_n;
      end
      ST_FCS: begin
        if (r_seq == LAST_FCS) begin
          w_state_n = ST_IFG;
          w_seq_n   = '0;
        end else begin
          w_en_n   = 1'b1;
          w_er_n   = r_urun_seen;
          w_seq_n  = r_seq + 8'd1;
          w_txd_n  = w_fcs_b;
          w_done_n = (r_seq == DONE_SEQ);
        end
      end
      ST_IFG: begin
        if (r_seq == LAST_IFG) begin
          w_state_n = ST_IDLE;
          w_busy_n  = 1'b0;
        end else begin
          w_seq_n = r_seq + 8'd1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pos       <= '0;
      r_seq       <= '0;
      r_crc       <= CRC_INIT;
      r_urun_seen <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      gmii_txd    <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pos       <= w_pos_n;
      r_seq       <= w_seq_n;
      r_urun_seen <= w_urun_seen_n;
      if (w_slot) r_crc <= w_crc_nx;
      gmii_tx_en  <= w_en_n;
      gmii_tx_er  <= w_er_n;
      gmii_txd    <= w_txd_n;
      busy        <= w_busy_n;
      frame_done  <= w_done_n;
      underrun    <= w_urun_n;
    end
  end

endmodule

// File: tb/tb_tx_gmii_frame_packer.sv
// Randomized bench for tx_gmii_frame_packer with a frame-level
// reference model compared every cycle.
module tb_tx_gmii_frame_packer;

  localparam int L    = 9;
  localparam int IFG  = 12;
  localparam int FL   = 8 + L + 4;
  localparam int SPAN = FL + IFG;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, fifo_rd_en;
  logic       fifo_rd_vld = 1'b0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       gmii_tx_en, gmii_tx_er;
  logic [7:0] gmii_txd;
  logic       frame_done, underrun;

  tx_gmii_frame_packer #(
    .PAYLOAD_LEN (L),
    .IFG_CYCLES  (IFG),
    .LEN_W       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .gmii_tx_en   (gmii_tx_en),
    .gmii_tx_er   (gmii_tx_er),
    .gmii_txd     (gmii_txd),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Bench-side FIFO (first-word fall-through)
  logic [7:0] fq[$];
  logic       stall = 1'b0;

  task automatic fifo_drive();
    fifo_rd_vld  = (fq.size() != 0) && !stall;
    fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic tick();
    logic pop;
    @(negedge clk);
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop && fq.size() != 0) fq.delete(0);
    fifo_drive();
  endtask

  // Frame-level model: idx is the position on the wire within
  // the current frame+gap, -1 when idle.
  int         idx = -1;
  int         fz = -1;
  logic [7:0] pay [L];

  int rden_cnt, urun_cnt, er_cnt, done_cnt;
  int en_run, last_run, gap_run, last_gap, blow_run, last_blow;
  logic [7:0] done_byte;
  logic [7:0] got[$];

  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int j = 0; j < L; j++) begin
      c ^= {24'h0, pay[j]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(negedge clk) begin
    logic       e_en, e_er, e_busy, e_done, e_urun, e_rd;
    logic [7:0] e_txd;
    int         p;
    e_en = 0; e_er = 0; e_busy = 0; e_done = 0;
    e_urun = 0; e_rd = 0; e_txd = 8'h00;
    if (rst) begin
      idx = -1;
    end else begin
      if (idx >= 0) begin
        e_busy = 1;
        if (idx < 7) begin
          e_en = 1; e_txd = 8'h55;
        end else if (idx == 7) begin
          e_en = 1; e_txd = 8'hD5;
        end else if (idx < 8 + L) begin
          p = idx - 8;
          e_en = 1; e_txd = pay[p];
          e_er = (fz >= 0) && (p >= fz);
          e_urun = (p == fz);
        end else if (idx < FL) begin
          p = idx - 8 - L;
          e_en = 1;
          e_txd = 8'(fcs_of() >> (8 * p));
          e_er = (fz >= 0);
          e_done = (idx == FL - 1);
        end
      end
      if (idx >= 7 && idx < 7 + L) begin
        e_rd = fifo_rd_vld;
        pay[idx-7] = fifo_rd_vld ? fifo_rd_data : 8'h00;
        if (!fifo_rd_vld && fz < 0) fz = idx - 7;
      end
    end
    chk("tx_en", 32'(gmii_tx_en), 32'(e_en));
    chk("tx_er", 32'(gmii_tx_er), 32'(e_er));
    chk("txd", 32'(gmii_txd), 32'(e_txd));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("underrun", 32'(underrun), 32'(e_urun));
    chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));

    if (fifo_rd_en) rden_cnt++;
    if (underrun) urun_cnt++;
    if (gmii_tx_er) er_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_byte = gmii_txd;
    end
    if (gmii_tx_en) begin
      en_run++;
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
      got.push_back(gmii_txd);
    end else begin
      if (en_run > 0) last_run = en_run;
      en_run = 0;
      gap_run++;
    end
    if (!busy) blow_run++;
    else begin
      if (blow_run > 0) last_blow = blow_run;
      blow_run = 0;
    end

    if (!rst) begin
      if (idx < 0) begin
        if (start) begin
          idx = 0;
          fz = -1;
        end
      end else begin
        idx++;
        if (idx == SPAN) idx = -1;
      end
    end
  end

  task automatic clr_stats();
    rden_cnt = 0; urun_cnt = 0; er_cnt = 0; done_cnt = 0;
    en_run = 0; last_run = 0; gap_run = 0; last_gap = 0;
    blow_run = 0; last_blow = 0; done_byte = 8'h00;
    got.delete();
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
    fifo_drive();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] exp_crc [21] = '{
    8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
    8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
    8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB
  };

  initial begin
    int nt;
    clr_stats();
    #1 rst = 1'b1;
    fifo_drive();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Known-answer frame: payload "123456789"
    clr_stats();
    for (int i = 0; i < 9; i++) fq.push_back(8'h31 + 8'(i));
    fifo_drive();
    pulse_start();
    repeat (40) tick();
    chk("crc_len", got.size(), 21);
    for (int i = 0; i < 21; i++)
      chk("crc_stream", (i < got.size()) ? 32'(got[i]) : 32'hFFFFFFFF,
          32'(exp_crc[i]));
    chk("crc_rd_cnt", rden_cnt, 9);
    chk("crc_en_run", last_run, 21);
    chk("crc_done_byte", 32'(done_byte), 32'hCB);
    chk("crc_done_cnt", done_cnt, 1);

    // Start held high: back-to-back frames
    clr_stats();
    fq.delete();
    push_rand(40);
    start = 1'b1;
    repeat (110) tick();
    start = 1'b0;
    repeat (30) tick();
    chk("b2b_gap", last_gap, 13);
    chk("b2b_busy_low", last_blow, 1);
    chk("b2b_frames", done_cnt, 4);
    chk("b2b_rd_cnt", rden_cnt, 36);

    // Underrun: only 5 of 9 bytes available
    clr_stats();
    fq.delete();
    push_rand(5);
    pulse_start();
    repeat (45) tick();
    chk("ur_rd_cnt", rden_cnt, 5);
    chk("ur_pulses", urun_cnt, 1);
    chk("ur_er_cycles", er_cnt, 8);
    chk("ur_en_run", last_run, 21);
    chk("ur_done_cnt", done_cnt, 1);

    // Starts while busy: mid-payload, in IFG, last IFG cycle
    clr_stats();
    fq.delete();
    push_rand(L);
    pulse_start();
    repeat (11) tick();
    pulse_start();
    repeat (15) tick();
    pulse_start();
    repeat (4) tick();
    pulse_start();
    repeat (30) tick();
    chk("busy_rd_cnt", rden_cnt, L);
    chk("busy_frames", done_cnt, 1);

    // Random payloads, stalls and stray starts
    for (int f = 0; f < 8; f++) begin
      fq.delete();
      push_rand($urandom_range(6, 12));
      pulse_start();
      nt = $urandom_range(34, 40);
      for (int t = 0; t < nt; t++) begin
        stall = f[0] && ($urandom_range(0, 7) == 0);
        start = ($urandom_range(0, 9) == 0);
        fifo_drive();
        tick();
      end
      start = 1'b0;
      stall = 1'b0;
      repeat (36) tick();
    end

    // Reset in the middle of payload byte 5
    fq.delete();
    push_rand(L);
    pulse_start();
    repeat (12) tick();
    chk("pre_rst_tx_en", 32'(gmii_tx_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("rst_tx_er", 32'(gmii_tx_er), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    fq.delete();
    push_rand(L);
    rst = 1'b0;
    tick();
    clr_stats();
    pulse_start();
    repeat (40) tick();
    chk("post_rst_frames", done_cnt, 1);
    chk("post_rst_rd_cnt", rden_cnt, L);
    chk("post_rst_en_run", last_run, 21);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
